// File: rtl/arb_req_queue_pkg.sv
// Shared definitions for the arbiter request queue: default sizing and
// grant-vector helpers used by the grant decode.
package arb_pkg;

   localparam int unsigned DefNumRequests = 8;
   localparam int unsigned DefDepth       = 4;
   localparam int unsigned DefDataWidth   = 32;

   // Widest grant vector the helpers accept; narrower vectors are zero-extended.
   localparam int unsigned MaxReq = 32;

   // True when exactly one bit of vec is set.
   function automatic logic is_onehot(input logic [MaxReq-1:0] vec);
      int unsigned ones;
      ones = 32'd0;
      for (int i = 0; i < MaxReq; i++) begin
         if (vec[i]) begin
            ones = ones + 32'd1;
         end else begin
            ones = ones;
         end
      end
      return (ones == 32'd1);
   endfunction

   // Index of the set bit of a one-hot vector (OR of set-bit indices).
   function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] vec);
      int unsigned idx;
      idx = 32'd0;
      for (int i = 0; i < MaxReq; i++) begin
         if (vec[i]) begin
            idx = idx | i;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_req_queue_if.sv
// Bundle of the push, arbiter and pop signals of arb_req_queue.
// Optional macro ARB_REQ_QUEUE_ERR_EN adds the sticky err_o flag.
interface arb_req_queue_if
   import arb_pkg::*;
#(
   parameter int unsigned NumRequests = DefNumRequests,
   parameter int unsigned Depth       = DefDepth,
   parameter int unsigned DataWidth   = DefDataWidth
);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [NumRequests-1:0]           push_valid_i;
   logic [NumRequests*DataWidth-1:0] push_data_i;
   logic [NumRequests-1:0]           push_ready_o;
   logic [NumRequests-1:0]           req_o;
   logic [NumRequests-1:0]           grnt_i;
   logic                             accept_i;
   logic                             pop_valid_o;
   logic [DataWidth-1:0]             pop_data_o;
   logic [NumRequests*CntW-1:0]      occupancy_o;
`ifdef ARB_REQ_QUEUE_ERR_EN
   logic                             err_o;

   modport master (
      output push_valid_i, push_data_i, grnt_i, accept_i,
      input  push_ready_o, req_o, pop_valid_o, pop_data_o, occupancy_o, err_o
   );
   modport slave (
      input  push_valid_i, push_data_i, grnt_i, accept_i,
      output push_ready_o, req_o, pop_valid_o, pop_data_o, occupancy_o, err_o
   );
`else
   modport master (
      output push_valid_i, push_data_i, grnt_i, accept_i,
      input  push_ready_o, req_o, pop_valid_o, pop_data_o, occupancy_o
   );
   modport slave (
      input  push_valid_i, push_data_i, grnt_i, accept_i,
      output push_ready_o, req_o, pop_valid_o, pop_data_o, occupancy_o
   );
`endif
endinterface

// File: rtl/arb_req_queue_req_fifo.sv
// Single-lane FIFO: registered pointers and count, unreset storage,
// combinational head. Push into a full lane and pop of an empty lane are ignored.
module req_fifo #(
   parameter int unsigned Depth     = 4,
   parameter int unsigned DataWidth = 32,
   localparam int unsigned CntW     = $clog2(Depth + 1),
   localparam int unsigned PtrW     = $clog2(Depth)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DataWidth-1:0] din,
   output logic [DataWidth-1:0] head,
   output logic [CntW-1:0]      count,
   output logic                 full,
   output logic                 empty
);
   logic [DataWidth-1:0] mem_r [Depth];
   logic [PtrW-1:0]      wptr_r;
   logic [PtrW-1:0]      rptr_r;
   logic [CntW-1:0]      count_r;
   logic                 push_ok_s;
   logic                 pop_ok_s;

   assign full      = (count_r == CntW'(Depth));
   assign empty     = (count_r == {CntW{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping; pointers wrap modulo Depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r  <= {PtrW{1'b0}};
         rptr_r  <= {PtrW{1'b0}};
         count_r <= {CntW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + PtrW'(1'b1);
         end else begin
            wptr_r <= wptr_r;
         end
         if (pop_ok_s) begin
            rptr_r <= rptr_r + PtrW'(1'b1);
         end else begin
            rptr_r <= rptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CntW'(1'b1);
            2'b01:   count_r <= count_r - CntW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Payload storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wptr_r] <= din;
      end else begin
         mem_r[wptr_r] <= mem_r[wptr_r];
      end
   end

endmodule

// File: rtl/arb_req_queue.sv
// Per-requester request buffer feeding a round-robin arbiter. One req_fifo
// per lane; req_o reflects non-empty lanes, and a legal one-hot grant
// presents the granted head downstream and pops it on accept.
// Optional macro ARB_REQ_QUEUE_ERR_EN adds a sticky err_o flag.
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int unsigned NumRequests = DefNumRequests,
   parameter int unsigned Depth       = DefDepth,
   parameter int unsigned DataWidth   = DefDataWidth
) (
   input logic                 clk,
   input logic                 rst,
   arb_req_queue_if.slave      bus
);
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned SelW = (NumRequests > 1) ? $clog2(NumRequests) : 1;

   logic [NumRequests-1:0] full_s;
   logic [NumRequests-1:0] empty_s;
   logic [NumRequests-1:0] push_s;
   logic [NumRequests-1:0] pop_s;
   logic [NumRequests-1:0] req_s;
   logic [NumRequests-1:0] ready_s;
   logic [DataWidth-1:0]   head_s  [NumRequests];
   logic [CntW-1:0]        count_s [NumRequests];
   logic                   onehot_s;
   logic [SelW-1:0]        sel_s;
   logic                   pop_valid_s;
   logic [DataWidth-1:0]   pop_data_s;

   for (genvar k = 0; k < NumRequests; k++) begin : g_lane
      // Ready and request come only from lane state; ready is held low in reset.
      assign ready_s[k] = ~rst & ~full_s[k];
      assign req_s[k]   = ~empty_s[k];
      assign push_s[k]  = bus.push_valid_i[k] & ready_s[k];
      assign pop_s[k]   = pop_valid_s & bus.accept_i & bus.grnt_i[k];

      req_fifo #(
         .Depth     (Depth),
         .DataWidth (DataWidth)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[k]),
         .pop   (pop_s[k]),
         .din   (bus.push_data_i[k*DataWidth +: DataWidth]),
         .head  (head_s[k]),
         .count (count_s[k]),
         .full  (full_s[k]),
         .empty (empty_s[k])
      );
   end

   // Grant decode: only a one-hot grant to a non-empty lane presents data.
   always_comb begin
      onehot_s = is_onehot(MaxReq'(bus.grnt_i));
      sel_s    = SelW'(onehot_to_idx(MaxReq'(bus.grnt_i)));
      if (onehot_s && req_s[sel_s]) begin
         pop_valid_s = 1'b1;
         pop_data_s  = head_s[sel_s];
      end else begin
         pop_valid_s = 1'b0;
         pop_data_s  = {DataWidth{1'b0}};
      end
   end

   // Pack per-lane counts into the flat occupancy vector.
   always_comb begin
      bus.occupancy_o = {(NumRequests*CntW){1'b0}};
      for (int k = 0; k < NumRequests; k++) begin
         bus.occupancy_o[k*CntW +: CntW] = count_s[k];
      end
   end

   assign bus.push_ready_o = ready_s;
   assign bus.req_o        = req_s;
   assign bus.pop_valid_o  = pop_valid_s;
   assign bus.pop_data_o   = pop_data_s;

`ifdef ARB_REQ_QUEUE_ERR_EN
   logic err_r;

   // Sticky error: accept with an illegal grant, or push into a full lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if ((bus.accept_i && !pop_valid_s) || (|(bus.push_valid_i & full_s))) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.err_o = err_r;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with a queue-based reference model and
// a per-cycle compare process, plus literal expectations per scenario.
module tb_arb_req_queue;
   import arb_pkg::*;

   localparam int NR = 8;
   localparam int DP = 4;
   localparam int DW = 32;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst;
   bit   chk_on = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [DW-1:0] mq [NR][$];

   always #5 clk = ~clk;

   arb_req_queue_if #(.NumRequests(NR), .Depth(DP), .DataWidth(DW)) bus();

   arb_req_queue #(.NumRequests(NR), .Depth(DP), .DataWidth(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the lane FIFOs as plain queues, updated by the rules.
   task automatic model_step();
      int g;
      bit pop_now;
      bit [NR-1:0] push_now;
      g = -1;
      if ($countones(bus.grnt_i) == 1) begin
         for (int k = 0; k < NR; k++) if (bus.grnt_i[k]) g = k;
      end
      pop_now = 1'b0;
      if (g >= 0) begin
         if (bus.accept_i && mq[g].size() > 0) pop_now = 1'b1;
      end
      for (int k = 0; k < NR; k++) push_now[k] = bus.push_valid_i[k] && (mq[k].size() < DP);
      if (pop_now) void'(mq[g].pop_front());
      for (int k = 0; k < NR; k++) begin
         if (push_now[k]) mq[k].push_back(bus.push_data_i[k*DW +: DW]);
      end
   endtask

   // Model advances on each clock edge and empties on reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NR; k++) mq[k].delete();
      end else begin
         model_step();
      end
   end

   task automatic compare_all();
      logic [NR-1:0]    e_req;
      logic [NR-1:0]    e_rdy;
      logic [NR*CW-1:0] e_occ;
      logic             e_pv;
      logic [DW-1:0]    e_pd;
      int g;
      e_occ = '0;
      for (int k = 0; k < NR; k++) begin
         e_req[k] = (mq[k].size() != 0);
         e_rdy[k] = !rst && (mq[k].size() != DP);
         e_occ[k*CW +: CW] = CW'(mq[k].size());
      end
      e_pv = 1'b0;
      e_pd = '0;
      g = -1;
      if ($countones(bus.grnt_i) == 1) begin
         for (int k = 0; k < NR; k++) if (bus.grnt_i[k]) g = k;
      end
      if (g >= 0) begin
         if (mq[g].size() > 0) begin
            e_pv = 1'b1;
            e_pd = mq[g][0];
         end
      end
      chk("cyc_req", 64'(bus.req_o), 64'(e_req));
      chk("cyc_ready", 64'(bus.push_ready_o), 64'(e_rdy));
      chk("cyc_occ", 64'(bus.occupancy_o), 64'(e_occ));
      chk("cyc_pop_valid", 64'(bus.pop_valid_o), 64'(e_pv));
      chk("cyc_pop_data", 64'(bus.pop_data_o), 64'(e_pd));
   endtask

   // Per-cycle comparison on the falling edge, away from state updates.
   always @(negedge clk) begin
      if (chk_on) compare_all();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.push_valid_i = '0;
      bus.grnt_i       = '0;
      bus.accept_i     = 1'b0;
   endtask

   task automatic push1(input int k, input logic [DW-1:0] d);
      bus.push_valid_i[k] = 1'b1;
      bus.push_data_i[k*DW +: DW] = d;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.push_data_i = '0;
      idle();
      chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(bus.push_ready_o), 64'h00);
      chk("rst_req", 64'(bus.req_o), 64'h00);
      chk("rst_occ", 64'(bus.occupancy_o), 64'h0);
      rst = 1'b0;
      #1;
      chk("rel_ready", 64'(bus.push_ready_o), 64'hFF);

      // Single push on lane 3 raises its request on the next cycle.
      tick(); push1(3, 32'h0000_00A5);
      #1 chk("t1_no_bypass", 64'(bus.req_o), 64'h00);
      tick(); idle();
      #1 chk("t1_req", 64'(bus.req_o), 64'h08);
      chk("t1_occ", 64'(bus.occupancy_o), 64'h000200);
      chk("t1_ready", 64'(bus.push_ready_o), 64'hFF);

      // Fill lane 0, then drain it in order; push on a full lane is refused.
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); push1(0, 32'h10 + 32'(i));
      end
      tick(); idle();
      #1 chk("t2_full_ready", 64'(bus.push_ready_o), 64'hFE);
      for (int i = 0; i < 4; i++) begin
         tick(); idle();
         bus.grnt_i = 8'h01;
         bus.accept_i = 1'b1;
         if (i == 0) push1(0, 32'h0000_0099);
         #1 chk("t2_pop_valid", 64'(bus.pop_valid_o), 64'h1);
         chk("t2_pop_data", 64'(bus.pop_data_o), 64'h10 + 64'(i));
      end
      tick(); idle();
      #1 chk("t2_req_after", 64'(bus.req_o), 64'h08);
      chk("t2_occ_after", 64'(bus.occupancy_o), 64'h000200);

      // Simultaneous push and pop on lane 2 keeps the count.
      tick(); idle(); push1(2, 32'h0000_0055);
      tick(); idle(); push1(2, 32'h0000_0066);
      bus.grnt_i = 8'h04;
      bus.accept_i = 1'b1;
      #1 chk("t3_pop_data", 64'(bus.pop_data_o), 64'h55);
      tick(); idle();
      #1 chk("t3_occ", 64'(bus.occupancy_o), 64'h000240);
      tick(); idle(); bus.grnt_i = 8'h04;
      #1 chk("t3_new_head", 64'(bus.pop_data_o), 64'h66);

      // Illegal grants: multi-hot, zero-hot, grant to an empty lane.
      tick(); idle(); bus.grnt_i = 8'b0000_0110; bus.accept_i = 1'b1;
      #1 chk("t4_multi_valid", 64'(bus.pop_valid_o), 64'h0);
      chk("t4_multi_data", 64'(bus.pop_data_o), 64'h0);
      tick(); idle(); bus.accept_i = 1'b1;
      #1 chk("t4_zero_valid", 64'(bus.pop_valid_o), 64'h0);
      tick(); idle(); bus.grnt_i = 8'h02; bus.accept_i = 1'b1;
      #1 chk("t4_empty_valid", 64'(bus.pop_valid_o), 64'h0);
      tick(); idle();
      #1 chk("t4_occ", 64'(bus.occupancy_o), 64'h000240);

      // Grant without accept holds the head; the accept pops exactly one.
      tick(); idle(); push1(5, 32'h0000_0077);
      tick(); idle(); push1(5, 32'h0000_0078);
      for (int i = 0; i < 3; i++) begin
         tick(); idle(); bus.grnt_i = 8'h20;
         #1 chk("t5_hold", 64'(bus.pop_data_o), 64'h77);
      end
      tick(); idle(); bus.grnt_i = 8'h20; bus.accept_i = 1'b1;
      #1 chk("t5_accept", 64'(bus.pop_data_o), 64'h77);
      tick(); idle(); bus.grnt_i = 8'h20;
      #1 chk("t5_next", 64'(bus.pop_data_o), 64'h78);
      chk("t5_occ", 64'(bus.occupancy_o), 64'h008240);

      // Reset in the middle of a pop discards everything at once.
      tick(); idle(); push1(1, 32'h0000_001A); push1(4, 32'h0000_004A);
      tick(); idle(); push1(1, 32'h0000_001B); push1(4, 32'h0000_004B);
      tick(); idle(); bus.grnt_i = 8'h02; bus.accept_i = 1'b1;
      #1 chk("t6_pop_data", 64'(bus.pop_data_o), 64'h1A);
      #1 rst = 1'b1;
      #1 chk("t6_rst_req", 64'(bus.req_o), 64'h00);
      chk("t6_rst_occ", 64'(bus.occupancy_o), 64'h0);
      chk("t6_rst_ready", 64'(bus.push_ready_o), 64'h00);
      chk("t6_rst_valid", 64'(bus.pop_valid_o), 64'h0);
      tick();
      tick(); rst = 1'b0; idle();
      #1 chk("t6_rel_ready", 64'(bus.push_ready_o), 64'hFF);
      chk("t6_rel_req", 64'(bus.req_o), 64'h00);
      bus.grnt_i = 8'h02; bus.accept_i = 1'b1;
      #1 chk("t6_stale_valid", 64'(bus.pop_valid_o), 64'h0);
      chk("t6_stale_data", 64'(bus.pop_data_o), 64'h0);
      tick(); idle(); push1(1, 32'h0000_00C3);
      tick(); idle(); bus.grnt_i = 8'h02;
      #1 chk("t6_fresh_data", 64'(bus.pop_data_o), 64'hC3);
      tick(); idle();
      tick();
      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
